fifo_stream_reader: RTL and testbench
=====================================

Name: fifo_stream_reader

Overview:
- Read-side engine for the FIFO_Sync buffer.
- Pops words from the FIFO read port (empty/rdEn/dataOut) and presents them on a valid/ready stream to the downstream consumer.
- Absorbs the FIFO's one-cycle read latency with a 2-entry output buffer, so it never underflows the FIFO and never drops a word under backpressure.
- Sustains one word per clock.

Parameters:
- WIDTH, 32, data word width; must match the FIFO WIDTH.
- CNT_W, 16, width of the forwarded-word counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rstN  input  1  synchronous active-low reset, sampled on rising edge of clk.
- enable  input  1  permits new FIFO reads when high.
- flush  input  1  single-cycle synchronous discard of buffered and in-flight data.
- fifoEmpty  input  1  FIFO empty flag.
- fifoData  input  WIDTH  FIFO dataOut; valid the cycle after rdEn is sampled high with fifoEmpty low.
- rdEn  output  1  FIFO read enable (combinational).
- outValid  output  1  outData holds a valid word.
- outReady  input  1  downstream accepts the word when outValid && outReady (pop).
- outData  output  WIDTH  head word of the output buffer.
- busy  output  1  high when state is not IDLE.
- wordCount  output  CNT_W  total words popped downstream; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rstN low at a clk edge):
  - buffer occupancy occ=0; inflight=0; state=IDLE; wordCount=0.
  - outValid=0, outData=0, busy=0.
  - rdEn=0 while rstN is low.
  - A read issued in the cycle before reset is discarded; its data is never captured.
- Read issue (combinational):
  - rdEn = rstN && enable && !flush && !fifoEmpty && (occ + inflight - pop) < 2.
  - rdEn is never high while fifoEmpty is high (no underflow).
- In-flight tracking: inflight <= rdEn on each edge; at most one read is outstanding.
- Capture: when inflight=1 and flush=0, fifoData is written into the buffer tail at that edge.
- Latency: rdEn high in cycle N -> fifoData valid in N+1 -> outValid high and outData = word in N+2 (2-cycle latency).
- Buffer ordering: 2-entry, strict FIFO order.
  - outData is always the oldest word.
  - While outValid=1 && outReady=0, outData is held stable.
  - Capture and pop in the same cycle: occ unchanged, order preserved.
- Throughput: with outReady held high and the FIFO non-empty, one word per clock in steady state; rdEn stays continuously high.
- Backpressure: with outReady=0, the buffer fills to 2 and rdEn deasserts. The capacity rule guarantees the in-flight word always has a free slot; the buffer never overflows.
- wordCount increments by 1 on every pop and wraps from 2^CNT_W-1 to 0. Flush does not clear it.
- flush=1 at an edge:
  - occ <= 0 and any in-flight word is discarded (not captured).
  - rdEn=0 in the flush cycle; outValid=0 the next cycle.
  - A pop in the same cycle as flush still counts toward wordCount.
- FSM, with transitions evaluated at each edge after the update:
  - IDLE: enable=0, occ=0, inflight=0. Go to RUN when enable=1.
  - RUN: enable=1. Go to STOP when enable=0 and (occ>0 or inflight). Go to IDLE when enable=0, occ=0 and no inflight.
  - STOP: enable=0; no new reads; the buffer drains downstream. Go to IDLE when occ=0 and no inflight. Go back to RUN if enable returns high.
  - flush in RUN keeps RUN. flush in STOP goes to IDLE.
- busy = (state != IDLE).
- Simultaneous enable fall and FIFO going empty: no read is issued; the buffer drains normally.

Test Plan:
- Reset: hold rstN=0 for 2 edges with fifoEmpty=0 and enable=1 -> rdEn=0, outValid=0, outData=0, wordCount=0, busy=0 throughout.
- Single word: FIFO holds 0x50, enable=1, outReady=1 -> rdEn high one cycle, outValid high exactly 2 cycles later with outData=0x50, wordCount=1, rdEn drops when fifoEmpty rises.
- Streaming: FIFO preloaded with 0..7 (DEPTH 8), outReady=1 -> outData 0,1,...,7 on 8 consecutive cycles, no bubbles, wordCount=8, then busy=0 after enable drops.
- Backpressure: outReady=0 with FIFO holding 0xA0..0xA4 -> exactly 2 reads issued, outData=0xA0 stable, rdEn=0. Release outReady -> 0xA0..0xA4 in order, none lost or duplicated.
- Flush with in-flight read: pulse flush in the cycle after an rdEn with occ=1 -> outValid=0 next cycle. The next FIFO word after the discarded one appears next, and wordCount is unchanged by the flush.
- Enable drop and reset mid-stream: deassert enable with occ=2 -> state STOP, no rdEn, both words popped, then IDLE. Repeat, then assert rstN=0 mid-stream -> all outputs return to reset values at that edge.

Source files
------------

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_reader
// Purpose  : Read-side engine for a synchronous FIFO. It pops words from the
//            FIFO read port (fifoEmpty / rdEn / fifoData) and presents them on
//            a valid/ready stream. A 2-entry output buffer hides the FIFO's
//            one-cycle read latency. The FIFO is never read while empty, and
//            no word is dropped when the consumer applies backpressure.
//            In steady state the block moves one word per clock.
// Ports    :
//   clk        in   system clock, rising edge
//   rstN       in   synchronous active-low reset
//   enable     in   permits new FIFO reads
//   flush      in   single-cycle discard of buffered and in-flight data
//   fifoEmpty  in   FIFO empty flag
//   fifoData   in   FIFO dataOut, valid the cycle after an accepted read
//   rdEn       out  FIFO read enable (combinational)
//   outValid   out  outData holds a valid word
//   outReady   in   consumer accepts the word when outValid && outReady
//   outData    out  oldest buffered word
//   busy       out  engine is not idle
//   wordCount  out  words handed downstream, modulo 2^CNT_W
// Revision : 1.0 - initial release
// ============================================================================
module fifo_stream_reader #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             enable,
    input  logic             flush,
    input  logic             fifoEmpty,
    input  logic [WIDTH-1:0] fifoData,
    output logic             rdEn,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] outData,
    output logic             busy,
    output logic [CNT_W-1:0] wordCount
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    state_t           state_q,    state_d;
    logic [1:0]       occ_q,      occ_d;
    logic             inflight_q, inflight_d;
    logic [WIDTH-1:0] head_q,     head_d;
    logic [WIDTH-1:0] tail_q,     tail_d;
    logic [CNT_W-1:0] count_q,    count_d;

    logic             w_pop;
    logic             w_capture;
    logic [2:0]       w_committed;

    assign w_pop     = (occ_q != 2'd0) && outReady;
    assign w_capture = inflight_q && !flush;

    // Slots already spoken for once this cycle's pop leaves: buffered words
    // plus the word still on its way from the FIFO. A new read is issued
    // only if a slot remains for its data, so the buffer can never overflow.
    assign w_committed = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, w_pop};

    assign rdEn = rstN && enable && !flush && !fifoEmpty && (w_committed < 3'd2);

    assign inflight_d = rdEn;

    // ------------------------------------------------------------------
    // Output buffer and word counter
    // ------------------------------------------------------------------
    always_comb begin
        occ_d   = occ_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        // A pop in the flush cycle still reached the consumer, so it counts.
        if (w_pop) begin
            count_d = count_q + CNT_W'(1);
        end

        if (flush) begin
            occ_d = 2'd0;
        end else begin
            occ_d = occ_q + {1'b0, w_capture} - {1'b0, w_pop};
            if (w_pop && (occ_q == 2'd2)) begin
                // Shift the younger word to the head; new data fills the tail.
                head_d = tail_q;
                if (w_capture) begin
                    tail_d = fifoData;
                end
            end else if (w_pop) begin
                // Single word leaves; any arriving word becomes the head.
                if (w_capture) begin
                    head_d = fifoData;
                end
            end else if (w_capture) begin
                if (occ_q == 2'd0) begin
                    head_d = fifoData;
                end else begin
                    tail_d = fifoData;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM: decisions use the post-update occupancy and in-flight
    // status so that the state always reflects what will be held after
    // this edge.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_RUN;
                end else if (!enable) begin
                    if ((occ_d != 2'd0) || inflight_d) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_STOP: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (enable) begin
                    state_d = ST_RUN;
                end else if ((occ_d == 2'd0) && !inflight_d) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q    <= ST_IDLE;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    assign outValid  = (occ_q != 2'd0);
    assign outData   = head_q;
    assign busy      = (state_q != ST_IDLE);
    assign wordCount = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_stream_reader
// Purpose  : Self-checking bench for fifo_stream_reader. It emulates the
//            source FIFO with a queue and predicts every output from a
//            queue-based model of the buffer, the in-flight read, the word
//            counter and the IDLE/RUN/STOP mode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rstN;
    logic             enable;
    logic             flush;
    logic             fifoEmpty;
    logic [WIDTH-1:0] fifoData;
    logic             rdEn;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] outData;
    logic             busy;
    logic [CNT_W-1:0] wordCount;

    always #5 clk = ~clk;

    fifo_stream_reader #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rstN      (rstN),
        .enable    (enable),
        .flush     (flush),
        .fifoEmpty (fifoEmpty),
        .fifoData  (fifoData),
        .rdEn      (rdEn),
        .outValid  (outValid),
        .outReady  (outReady),
        .outData   (outData),
        .busy      (busy),
        .wordCount (wordCount)
    );

    int checks = 0;
    int errors = 0;

    // Emulated source FIFO
    logic [WIDTH-1:0] fq[$];
    bit               fifo_pop_pend;

    // Reference model
    logic [WIDTH-1:0] mq[$];
    bit               m_infl;
    logic [WIDTH-1:0] m_infl_word;
    logic [CNT_W-1:0] m_cnt;
    int               m_state;   // 0 idle, 1 run, 2 stop
    bit               m_live = 1'b0;

    // Values observed mid-cycle during the last step
    logic             s_rdEn;
    logic             s_outValid;
    logic [WIDTH-1:0] s_outData;
    logic [WIDTH-1:0] popped[$];
    int               rd_count;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fpush(input logic [WIDTH-1:0] w);
        fq.push_back(w);
        fifoEmpty = 1'b0;
    endtask

    // One clock cycle: compare at the falling edge, advance model at the
    // rising edge, then update FIFO emulation just after it.
    task automatic step();
        bit exp_valid;
        bit pop;
        bit exp_rd;
        @(negedge clk);
        s_rdEn     = rdEn;
        s_outValid = outValid;
        s_outData  = outData;
        exp_valid  = (mq.size() > 0);
        pop        = exp_valid && outReady;
        exp_rd     = rstN && enable && !flush && !fifoEmpty &&
                     ((mq.size() + int'(m_infl) - int'(pop)) < 2);
        if (m_live) begin
            chk("rdEn", rdEn, exp_rd);
            chk("outValid", outValid, exp_valid);
            if (exp_valid) chk("outData", outData, mq[0]);
            chk("wordCount", wordCount, m_cnt);
            chk("busy", busy, m_state != 0);
        end
        if (outValid && outReady) popped.push_back(outData);
        fifo_pop_pend = rdEn && !fifoEmpty;
        @(posedge clk);
        if (!rstN) begin
            mq.delete();
            m_infl  = 1'b0;
            m_cnt   = '0;
            m_state = 0;
            m_live  = 1'b1;
        end else if (m_live) begin
            if (pop) begin
                m_cnt++;
                void'(mq.pop_front());
            end
            if (flush) mq.delete();
            else if (m_infl) mq.push_back(m_infl_word);
            case (m_state)
                0: if (enable) m_state = 1;
                1: if (!flush && !enable) m_state = (mq.size() > 0 || exp_rd) ? 2 : 0;
                default: begin
                    if (flush) m_state = 0;
                    else if (enable) m_state = 1;
                    else if (mq.size() == 0) m_state = 0;
                end
            endcase
            m_infl = exp_rd;
            if (exp_rd) m_infl_word = fq[0];
        end
        #1;
        if (fifo_pop_pend) fifoData = fq.pop_front();
        fifoEmpty = (fq.size() == 0);
    endtask

    initial begin
        rstN = 1'b0; enable = 1'b1; flush = 1'b0; outReady = 1'b1;
        fifoData = '0; fifoEmpty = 1'b1;
        fpush(32'h50);

        // Reset held two edges with a non-empty FIFO and enable high
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_rdEn", s_rdEn, 1'b0);
            chk("rst_outValid", outValid, 1'b0);
            chk("rst_outData", outData, 32'h0);
            chk("rst_wordCount", wordCount, 4'd0);
            chk("rst_busy", busy, 1'b0);
        end

        // Single word with 2-cycle latency
        rstN = 1'b1;
        step(); chk("single_rd_issue", s_rdEn, 1'b1);
        step(); chk("single_rd_drop", s_rdEn, 1'b0); chk("single_not_yet", s_outValid, 1'b0);
        step(); chk("single_valid", s_outValid, 1'b1); chk("single_data", s_outData, 32'h50);
        chk("single_count", wordCount, 4'd1);

        // Streaming 0..7 with no bubbles
        for (int i = 0; i < 8; i++) fpush(i);
        for (int i = 0; i < 12; i++) begin
            step();
            if (i >= 2 && i < 10) begin
                chk("stream_valid", s_outValid, 1'b1);
                chk("stream_data", s_outData, i - 2);
            end
        end
        chk("stream_count", wordCount, 4'd9);
        enable = 1'b0;
        step(); chk("stream_idle", busy, 1'b0);

        // Backpressure: exactly two reads, head held
        enable = 1'b1; outReady = 1'b0; rd_count = 0;
        for (int i = 0; i < 5; i++) fpush(32'hA0 + i);
        for (int i = 0; i < 6; i++) begin
            step();
            rd_count += int'(s_rdEn);
            if (i >= 2) chk("bp_hold", s_outData, 32'hA0);
        end
        chk("bp_reads", rd_count, 2);
        chk("bp_rd_low", s_rdEn, 1'b0);
        outReady = 1'b1; popped.delete();
        for (int i = 0; i < 8; i++) step();
        chk("bp_popcount", popped.size(), 5);
        for (int k = 0; k < 5 && k < popped.size(); k++) chk("bp_order", popped[k], 32'hA0 + k);
        enable = 1'b0; step(); step();

        // Flush with a read in flight and one word buffered
        enable = 1'b1; outReady = 1'b0;
        fpush(32'hB0); fpush(32'hB1); fpush(32'hB2);
        step(); step();
        flush = 1'b1;
        step(); chk("flush_rd_low", s_rdEn, 1'b0);
        flush = 1'b0;
        chk("flush_count", wordCount, 4'd14);
        outReady = 1'b1; popped.delete();
        step(); chk("flush_invalid", s_outValid, 1'b0);
        for (int i = 0; i < 3; i++) step();
        chk("flush_next_n", popped.size(), 1);
        if (popped.size() > 0) chk("flush_next_word", popped[0], 32'hB2);
        chk("flush_count2", wordCount, 4'd15);

        // Enable drop with a full buffer: STOP, drain, IDLE; counter wraps
        outReady = 1'b0;
        for (int i = 0; i < 4; i++) fpush(32'hD0 + i);
        for (int i = 0; i < 4; i++) step();
        enable = 1'b0;
        step(); chk("stop_rd", s_rdEn, 1'b0); chk("stop_busy", busy, 1'b1);
        outReady = 1'b1; popped.delete();
        step(); chk("drain_rd0", s_rdEn, 1'b0); chk("wrap_count", wordCount, 4'd0);
        step(); chk("drain_rd1", s_rdEn, 1'b0); chk("drain_idle", busy, 1'b0);
        chk("drain_n", popped.size(), 2);
        if (popped.size() == 2) begin
            chk("drain_w0", popped[0], 32'hD0);
            chk("drain_w1", popped[1], 32'hD1);
        end

        // Restart then reset mid-stream
        enable = 1'b1;
        for (int i = 0; i < 4; i++) fpush(32'hE0 + i);
        step(); step(); step();
        rstN = 1'b0;
        step();
        chk("midrst_rd", s_rdEn, 1'b0);
        chk("midrst_valid", outValid, 1'b0);
        chk("midrst_data", outData, 32'h0);
        chk("midrst_count", wordCount, 4'd0);
        chk("midrst_busy", busy, 1'b0);
        rstN = 1'b1;

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 15) == 0) enable = ~enable;
            outReady = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 49) == 0);
            rstN     = ($urandom_range(0, 499) != 0);
            if (fq.size() < 8 && $urandom_range(0, 2) != 0) fpush($urandom);
            step();
        end
        rstN = 1'b1; flush = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
